// File: rtl/jtdd_prog_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// jtdd_prog_pkg : shared widths and FSM encoding for the download scheduler
// Revision 1.0
// ============================================================================
package jtdd_prog_pkg;

  localparam int PKG_AW = 22;
  localparam int DATA_W = 8;
  localparam int MASK_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // FIFO entry layout is {addr, data, mask}, MSB first
  function automatic int entry_w(input int aw);
    return aw + DATA_W + MASK_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtdd_prog_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// jtdd_prog_fifo : synchronous FIFO with registered full/empty flags
// Revision 1.0
// ============================================================================
module jtdd_prog_fifo #(
  parameter int W        = 32,
  parameter int DEPTH_L2 = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << DEPTH_L2;

  logic [DEPTH_L2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_L2:0] rd_ptr_q, rd_ptr_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              push_ok, pop_ok;
  logic [W-1:0]      mem_q [DEPTH];

  // Push is judged against the flag before any same-cycle pop
  always_comb begin
    push_ok  = push & ~full_q;
    pop_ok   = pop & ~empty_q;
    wr_ptr_d = wr_ptr_q + {{DEPTH_L2{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{DEPTH_L2{1'b0}}, pop_ok};
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[DEPTH_L2] != rd_ptr_d[DEPTH_L2]) &&
               (wr_ptr_d[DEPTH_L2-1:0] == rd_ptr_d[DEPTH_L2-1:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[DEPTH_L2-1:0]] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q[DEPTH_L2-1:0]];
  assign full  = full_q;
  assign empty = empty_q;

endmodule
`default_nettype wire

// File: rtl/jtdd_prog_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// jtdd_prog_sched : queues ROM-download byte writes and issues them to SDRAM
// Revision 1.0
// ============================================================================
module jtdd_prog_sched
  import jtdd_prog_pkg::*;
#(
  parameter int AW       = PKG_AW,
  parameter int DEPTH_L2 = 3,
  parameter int TOUT     = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic [1:0]    prog_mask,
  input  logic          prog_we,
  output logic [AW-1:0] sdram_addr,
  output logic [15:0]   sdram_din,
  output logic [1:0]    sdram_dqm,
  output logic          sdram_req,
  input  logic          sdram_ack,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic          timeout
);

  localparam int        EW        = entry_w(AW);
  localparam logic [7:0] TOUT_LAST = 8'(TOUT - 1);

  logic [EW-1:0] fifo_wdata, fifo_rdata;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [AW-1:0] head_addr;
  logic [7:0]    head_data;
  logic [1:0]    head_mask;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   din_q, din_d;
  logic [1:0]    dqm_q, dqm_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          overflow_q, overflow_d;
  logic          timeout_q, timeout_d;
  logic          dl_q, dl_d;
  logic          busy_q, busy_d;
  logic          busy_now;

  assign fifo_wdata = {prog_addr, prog_data, prog_mask};
  assign head_addr  = fifo_rdata[EW-1 -: AW];
  assign head_data  = fifo_rdata[MASK_W +: DATA_W];
  assign head_mask  = fifo_rdata[MASK_W-1:0];

  jtdd_prog_fifo #(
    .W        (EW),
    .DEPTH_L2 (DEPTH_L2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (prog_we),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    din_d      = din_q;
    dqm_d      = dqm_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    fifo_pop   = 1'b0;
    dl_d       = downloading;

    // A new download window starts with clean error flags; a fresh event still wins
    if (downloading && !dl_q) begin
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
    end
    if (prog_we && fifo_full) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          addr_d   = head_addr;
          din_d    = {head_data, head_data};
          dqm_d    = head_mask;
          req_d    = 1'b1;
          cnt_d    = 8'd0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == TOUT_LAST) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_now = downloading | ~fifo_empty | (state_q != ST_IDLE);
    busy_d   = busy_now;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      dqm_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      dl_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      dqm_q      <= dqm_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      dl_q       <= dl_d;
      busy_q     <= busy_d;
    end
  end

  // busy low implies downloading low, so done can never fire inside a window
  assign busy       = busy_now;
  assign done       = busy_q & ~busy_now;
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;
  assign sdram_din  = din_q;
  assign sdram_dqm  = dqm_q;
  assign overflow   = overflow_q;
  assign timeout    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_jtdd_prog_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_jtdd_prog_sched : scoreboard bench for the ROM-download write scheduler
// Revision 1.0
// ============================================================================
module tb_jtdd_prog_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        downloading;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic [21:0] sdram_addr;
  logic [15:0] sdram_din;
  logic [1:0]  sdram_dqm;
  logic        sdram_req;
  logic        sdram_ack;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        timeout;

  typedef struct packed {
    logic [21:0] addr;
    logic [15:0] din;
    logic [1:0]  dqm;
  } wr_t;

  wr_t  exp_q[$];
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   n_issue = 0;
  logic req_prev = 1'b0;

  always #5 clk = ~clk;

  jtdd_prog_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_we     (prog_we),
    .sdram_addr  (sdram_addr),
    .sdram_din   (sdram_din),
    .sdram_dqm   (sdram_dqm),
    .sdram_req   (sdram_req),
    .sdram_ack   (sdram_ack),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .timeout     (timeout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [21:0] a, input logic [7:0] d, input logic [1:0] m,
                         input bit will_issue);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    prog_mask = m;
    if (will_issue) exp_q.push_back('{a, {d, d}, m});
  endtask

  task automatic ack_after(input int n);
    int w;
    w = 0;
    while (!sdram_req && w < 50) begin
      next();
      w++;
    end
    chk("req_wait", sdram_req, 1);
    repeat (n) next();
    sdram_ack = 1'b1;
    next();
    sdram_ack = 1'b0;
  endtask

  // Every rising edge of sdram_req is one issued write; compare against the head
  always @(negedge clk) begin
    if (sdram_req && !req_prev) begin
      n_issue <= n_issue + 1;
      chk("issue_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        chk("issue_addr", sdram_addr, exp_q[0].addr);
        chk("issue_din", sdram_din, exp_q[0].din);
        chk("issue_dqm", sdram_dqm, exp_q[0].dqm);
        void'(exp_q.pop_front());
      end
    end
    req_prev <= sdram_req;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, k5, na, nreq, ndone;
    rst_n = 1'b0; downloading = 1'b0; prog_we = 1'b0; sdram_ack = 1'b0;
    prog_addr = '0; prog_data = '0; prog_mask = '0;
    repeat (3) next();
    chk("reset_req", sdram_req, 0);
    chk("reset_addr", sdram_addr, 0);
    chk("reset_din", sdram_din, 0);
    chk("reset_dqm", sdram_dqm, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_timeout", timeout, 0);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    next();
    rst_n = 1'b1;
    next();

    // Single write
    downloading = 1'b1;
    push_wr(22'h20001, 8'hA5, 2'b01, 1'b1);
    next();
    prog_we = 1'b0;
    chk("t1_req_not_yet", sdram_req, 0);
    next();
    chk("t1_req", sdram_req, 1);
    chk("t1_addr", sdram_addr, 22'h20001);
    chk("t1_din", sdram_din, 16'hA5A5);
    chk("t1_dqm", sdram_dqm, 2'b01);
    repeat (3) next();
    chk("t1_req_held", sdram_req, 1);
    sdram_ack = 1'b1;
    next();
    sdram_ack = 1'b0;
    chk("t1_req_drop", sdram_req, 0);
    downloading = 1'b0;
    @(negedge clk);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    next();
    @(negedge clk);
    chk("t1_done_single", done, 0);
    next();

    // Burst: first entry goes out at once, next 8 fill the FIFO, the 10th overflows
    downloading = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push_wr(22'(i + 'h100), 8'(i + 'h10), (i % 2 == 1) ? 2'b10 : 2'b01, 1'b1);
      next();
    end
    chk("t2_no_ovf_at_full", overflow, 0);
    push_wr(22'h3FFFFF, 8'hEE, 2'b00, 1'b0);
    next();
    prog_we = 1'b0;
    chk("t2_overflow", overflow, 1);
    chk("t2_req_first", sdram_req, 1);
    chk("t2_addr_first", sdram_addr, 22'h100);

    // Push with ack at full, then push with pop at full: both dropped
    sdram_ack = 1'b1;
    push_wr(22'h3FFFFE, 8'hEF, 2'b00, 1'b0);
    next();
    sdram_ack = 1'b0;
    push_wr(22'h3FFFFD, 8'hF0, 2'b00, 1'b0);
    next();
    chk("t6_addr_second", sdram_addr, 22'h101);
    push_wr(22'h200, 8'h5C, 2'b10, 1'b1);
    next();
    prog_we = 1'b0;
    repeat (9) ack_after(1);
    chk("t6_queue_drained", exp_q.size(), 0);
    chk("t2_ovf_sticky", overflow, 1);
    downloading = 1'b0;
    next();
    downloading = 1'b1;
    next();
    chk("t2_ovf_cleared", overflow, 0);
    chk("t3_timeout_clear", timeout, 0);

    // Ack never arrives for the first write
    push_wr(22'h3A000, 8'h11, 2'b00, 1'b1);
    next();
    push_wr(22'h3A001, 8'h22, 2'b11, 1'b1);
    next();
    prog_we = 1'b0;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (!sdram_req) break;
      cnt++;
      next();
    end
    chk("t3_req_cycles", cnt, 255);
    chk("t3_timeout", timeout, 1);
    next();
    chk("t3_next_issue", sdram_req, 1);
    ack_after(0);
    chk("t3_timeout_sticky", timeout, 1);

    // Window closes with 5 writes outstanding; ack on every request
    for (int i = 0; i < 5; i++) begin
      push_wr(22'(i + 'h1000), 8'(i + 'hC0), 2'b00, 1'b1);
      next();
    end
    prog_we = 1'b0;
    downloading = 1'b0;
    k5 = -1;
    na = 0;
    for (int k = 0; k < 30; k++) begin
      if (sdram_req && na < 5) begin
        sdram_ack = 1'b1;
        na++;
        if (na == 5) k5 = k;
      end else begin
        sdram_ack = 1'b0;
      end
      @(negedge clk);
      chk("t4_busy", busy, (k5 < 0 || k <= k5) ? 1 : 0);
      chk("t4_done", done, (k5 >= 0 && k == k5 + 1) ? 1 : 0);
      next();
    end
    sdram_ack = 1'b0;
    chk("t4_all_acked", na, 5);

    // Reset with one write in flight and four queued
    downloading = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_wr(22'(i + 'h2000), 8'(i + 'h30), 2'b01, i == 0);
      next();
    end
    prog_we = 1'b0;
    chk("t5_req_before", sdram_req, 1);
    rst_n = 1'b0;
    downloading = 1'b0;
    next();
    chk("t5_req", sdram_req, 0);
    chk("t5_addr", sdram_addr, 0);
    chk("t5_din", sdram_din, 0);
    chk("t5_dqm", sdram_dqm, 0);
    chk("t5_overflow", overflow, 0);
    chk("t5_timeout", timeout, 0);
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    next();
    rst_n = 1'b1;
    nreq = 0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sdram_req) nreq++;
      if (done) ndone++;
      next();
    end
    chk("t5_no_spurious_req", nreq, 0);
    chk("t5_no_done", ndone, 0);

    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_issue_count", n_issue, 19);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
